dbus_controller: RTL and testbench

- Shares the single CPU data bus between two requesters: m0 (CPU load/store unit) and m1 (DMA/debug port).
- Fair round-robin arbitration, address decode into the 9-bit chip_select_t one-hot, fixed read-latency tracking, and routing of read data back to the owning requester.
- Sits between the requesters and the bios/ram/vram/keyboard/display/switches/uart/irq/vga devices.

---
 rtl/dbus_controller.sv | 193 +++++++++++++++++++
 tb/tb_dbus_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_controller.sv
//==============================================================================
// dbus_controller : round-robin arbiter, region decoder and fixed-latency read
// tracker sharing the CPU data bus between m0 (LSU) and m1 (DMA/debug).
// Optional macro DBUS_DECODE_ERR_EN enables decode-error pulses on m0/m1_err_o.
// Revision: 1.0
//==============================================================================
`default_nettype none

module dbus_controller #(
    parameter int READ_LATENCY = 1,
    parameter int REGION_LSB   = 28
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_wr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_wmask_i,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_wr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_wmask_i,
    output logic        m0_gnt_o,
    output logic        m1_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic [31:0] m1_rdata_o,
    output logic        m0_err_o,
    output logic        m1_err_o,
    output logic [8:0]  bus_cs_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wmask_o,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    localparam logic [1:0] c_LAT_M1 = 2'(READ_LATENCY - 1);

    state_t      state_q;
    logic        last_q;
    logic        owner_q;
    logic        wr_q;
    logic        unmapped_q;
    logic [1:0]  cnt_q;
    logic [8:0]  bus_cs_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [3:0]  bus_wmask_q;
    logic        rvalid0_q;
    logic        rvalid1_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic        w_gnt0;
    logic        w_gnt1;
    logic [31:0] w_addr;
    logic        w_wr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wmask;
    logic [3:0]  w_region;
    logic [8:0]  w_cs;

    // last_q holds the most recent owner; resetting it to m1 makes m0 preferred.
    assign w_gnt0 = (state_q == S_IDLE) && m0_req_i && (!m1_req_i || last_q);
    assign w_gnt1 = (state_q == S_IDLE) && m1_req_i && (!m0_req_i || !last_q);

    assign w_addr   = w_gnt1 ? m1_addr_i  : m0_addr_i;
    assign w_wr     = w_gnt1 ? m1_wr_i    : m0_wr_i;
    assign w_wdata  = w_gnt1 ? m1_wdata_i : m0_wdata_i;
    assign w_wmask  = w_gnt1 ? m1_wmask_i : m0_wmask_i;
    assign w_region = w_addr[REGION_LSB+3 -: 4];
    assign w_cs     = (w_region <= 4'd8) ? (9'd1 << w_region) : 9'd0;

`ifdef DBUS_DECODE_ERR_EN
    logic err0_q;
    logic err1_q;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            wr_q        <= 1'b0;
            unmapped_q  <= 1'b0;
            cnt_q       <= 2'd0;
            bus_cs_q    <= 9'd0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_wmask_q <= 4'd0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= 32'd0;
            rdata1_q    <= 32'd0;
`ifdef DBUS_DECODE_ERR_EN
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
`endif
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
`ifdef DBUS_DECODE_ERR_EN
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        owner_q     <= w_gnt1;
                        last_q      <= w_gnt1;
                        wr_q        <= w_wr;
                        unmapped_q  <= (w_region > 4'd8);
                        bus_cs_q    <= w_cs;
                        bus_addr_q  <= w_addr;
                        bus_wdata_q <= w_wdata;
                        bus_wmask_q <= w_wr ? w_wmask : 4'd0;
                        state_q     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    bus_cs_q    <= 9'd0;
                    bus_addr_q  <= 32'd0;
                    bus_wdata_q <= 32'd0;
                    bus_wmask_q <= 4'd0;
                    if (wr_q) begin
                        state_q <= S_IDLE;
`ifdef DBUS_DECODE_ERR_EN
                        if (unmapped_q) begin
                            err0_q <= !owner_q;
                            err1_q <= owner_q;
                        end
`endif
                    end else begin
                        cnt_q   <= c_LAT_M1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= S_IDLE;
                        if (owner_q) begin
                            rvalid1_q <= 1'b1;
                            rdata1_q  <= unmapped_q ? 32'd0 : bus_rdata_i;
                        end else begin
                            rvalid0_q <= 1'b1;
                            rdata0_q  <= unmapped_q ? 32'd0 : bus_rdata_i;
                        end
`ifdef DBUS_DECODE_ERR_EN
                        if (unmapped_q) begin
                            err0_q <= !owner_q;
                            err1_q <= owner_q;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m0_gnt_o    = w_gnt0;
    assign m1_gnt_o    = w_gnt1;
    assign m0_rvalid_o = rvalid0_q;
    assign m1_rvalid_o = rvalid1_q;
    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;
    assign bus_cs_o    = bus_cs_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_wmask_o = bus_wmask_q;

`ifdef DBUS_DECODE_ERR_EN
    assign m0_err_o = err0_q;
    assign m1_err_o = err1_q;
`else
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dbus_controller.sv
//==============================================================================
// tb_dbus_controller : directed and random stimulus against a cycle-timeline
// reference model of dbus_controller.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_dbus_controller;

    localparam int c_RL = 4;
`ifdef DBUS_DECODE_ERR_EN
    localparam bit c_ERR = 1'b1;
`else
    localparam bit c_ERR = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
    logic        m0_wr_i = 1'b0, m1_wr_i = 1'b0;
    logic [31:0] m0_wdata_i = '0, m1_wdata_i = '0;
    logic [3:0]  m0_wmask_i = '0, m1_wmask_i = '0;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o, bus_addr_o, bus_wdata_o;
    logic [8:0]  bus_cs_o;
    logic [3:0]  bus_wmask_o;
    logic [31:0] bus_rdata_i = '0;

    dbus_controller #(.READ_LATENCY(c_RL), .REGION_LSB(28)) u_dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_wr_i(m0_wr_i),
        .m0_wdata_i(m0_wdata_i), .m0_wmask_i(m0_wmask_i),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_wr_i(m1_wr_i),
        .m1_wdata_i(m1_wdata_i), .m1_wmask_i(m1_wmask_i),
        .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
        .m0_rdata_o(m0_rdata_o), .m1_rdata_o(m1_rdata_o),
        .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
        .bus_cs_o(bus_cs_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wmask_o(bus_wmask_o),
        .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Requester intent
    logic        p_req[2];
    logic [31:0] p_addr[2];
    logic        p_wr[2];
    logic [31:0] p_wdata[2];
    logic [3:0]  p_mask[2];
    logic        p_rst;

    // Reference model: absolute cycle numbers of each future event
    int          cyc = 0;
    int          idle_from = 0;
    int          acc_cyc = -1, smp_cyc = -1, rv_cyc = -1, err_cyc = -1;
    int          obs_g[2];
    int          obs_rv[2];
    logic        last = 1'b1;
    logic        rv_own, err_own, pend_unm;
    logic [8:0]  e_cs;
    logic [31:0] e_addr, e_wdata, rv_data;
    logic [3:0]  e_wmask;
    logic [31:0] e_rd[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(input int m, input logic [31:0] a, input logic wr,
                           input logic [31:0] d, input logic [3:0] mk);
        p_req[m] = 1'b1; p_addr[m] = a; p_wr[m] = wr; p_wdata[m] = d; p_mask[m] = mk;
    endtask

    task automatic tick();
        logic       idle, g0, g1, o, unm;
        logic [3:0] r;
        @(posedge clk_i); #1;
        reset_i    = p_rst;
        m0_req_i   = p_req[0]; m0_addr_i = p_addr[0]; m0_wr_i = p_wr[0];
        m0_wdata_i = p_wdata[0]; m0_wmask_i = p_mask[0];
        m1_req_i   = p_req[1]; m1_addr_i = p_addr[1]; m1_wr_i = p_wr[1];
        m1_wdata_i = p_wdata[1]; m1_wmask_i = p_mask[1];
        bus_rdata_i = $urandom();
        #1;
        idle = (cyc >= idle_from);
        g0 = idle && p_req[0] && (!p_req[1] || last == 1'b1);
        g1 = idle && p_req[1] && (!p_req[0] || last == 1'b0);
        if (cyc == smp_cyc) rv_data = pend_unm ? 32'd0 : bus_rdata_i;
        if (cyc == rv_cyc) e_rd[rv_own] = rv_data;
        if (m1_gnt_o) obs_g[1] = cyc;
        if (m0_gnt_o) obs_g[0] = cyc;
        if (m0_rvalid_o) obs_rv[0] = cyc;
        chk("m0_gnt", {31'd0, m0_gnt_o}, {31'd0, g0});
        chk("m1_gnt", {31'd0, m1_gnt_o}, {31'd0, g1});
        chk("bus_cs", {23'd0, bus_cs_o}, (cyc == acc_cyc) ? {23'd0, e_cs} : 32'd0);
        chk("bus_addr", bus_addr_o, (cyc == acc_cyc) ? e_addr : 32'd0);
        chk("bus_wdata", bus_wdata_o, (cyc == acc_cyc) ? e_wdata : 32'd0);
        chk("bus_wmask", {28'd0, bus_wmask_o}, (cyc == acc_cyc) ? {28'd0, e_wmask} : 32'd0);
        chk("m0_rvalid", {31'd0, m0_rvalid_o}, {31'd0, (cyc == rv_cyc && rv_own == 1'b0)});
        chk("m1_rvalid", {31'd0, m1_rvalid_o}, {31'd0, (cyc == rv_cyc && rv_own == 1'b1)});
        chk("m0_rdata", m0_rdata_o, e_rd[0]);
        chk("m1_rdata", m1_rdata_o, e_rd[1]);
        chk("m0_err", {31'd0, m0_err_o}, {31'd0, (cyc == err_cyc && err_own == 1'b0)});
        chk("m1_err", {31'd0, m1_err_o}, {31'd0, (cyc == err_cyc && err_own == 1'b1)});
        // Advance the model across the coming edge
        if (p_rst) begin
            idle_from = cyc + 1; acc_cyc = -1; smp_cyc = -1; rv_cyc = -1; err_cyc = -1;
            last = 1'b1; e_rd[0] = '0; e_rd[1] = '0;
        end else if (g0 || g1) begin
            o = g1;
            r = p_addr[o][31:28];
            unm = (r > 4'd8);
            acc_cyc = cyc + 1;
            e_cs    = unm ? 9'd0 : (9'd1 << r);
            e_addr  = p_addr[o];
            e_wdata = p_wdata[o];
            e_wmask = p_wr[o] ? p_mask[o] : 4'd0;
            last    = o;
            if (p_wr[o]) begin
                idle_from = cyc + 2;
                if (unm && c_ERR) begin err_cyc = cyc + 2; err_own = o; end
            end else begin
                smp_cyc = cyc + 1 + c_RL; rv_cyc = cyc + 2 + c_RL; rv_own = o;
                pend_unm = unm; idle_from = cyc + 2 + c_RL;
                if (unm && c_ERR) begin err_cyc = rv_cyc; err_own = o; end
            end
            p_req[o] = 1'b0;
        end
        cyc++;
    endtask

    task automatic wait_gnt(input int m);
        for (int i = 0; i < 40 && p_req[m]; i++) tick();
        chk("gnt_timeout", {31'd0, p_req[m]}, 32'd0);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int          g;
        logic [31:0] a;
        for (int m = 0; m < 2; m++) begin
            p_req[m] = 1'b0; p_addr[m] = '0; p_wr[m] = 1'b0; p_wdata[m] = '0; p_mask[m] = '0;
            e_rd[m] = '0; obs_g[m] = -1; obs_rv[m] = -1;
        end
        repeat (2) @(posedge clk_i);
        p_rst = 1'b1;
        idle_ticks(2);
        p_rst = 1'b0;

        // Reset in the middle of an outstanding read
        set_req(0, 32'h1000_0000, 1'b0, 32'h0, 4'h0);
        idle_ticks(3);
        p_rst = 1'b1;
        idle_ticks(3);
        p_rst = 1'b0;
        set_req(0, 32'h1000_0004, 1'b1, 32'h1111_1111, 4'hF);
        set_req(1, 32'h1000_0008, 1'b1, 32'h2222_2222, 4'hF);
        tick();
        chk("post_rst_m0_first", {31'd0, p_req[0]}, 32'd0);
        wait_gnt(1);
        idle_ticks(c_RL + 3);

        // Single read from ram and a single write to uart
        set_req(0, 32'h1000_0040, 1'b0, 32'h0, 4'hF);
        wait_gnt(0);
        idle_ticks(c_RL + 3);
        set_req(1, 32'h6000_0000, 1'b1, 32'h41, 4'b0001);
        wait_gnt(1);
        idle_ticks(3);

        // Both masters streaming writes
        for (int i = 0; i < 8; i++) begin
            for (int m = 0; m < 2; m++)
                if (!p_req[m]) set_req(m, 32'h2000_0000 + 32'(i * 8 + m * 4), 1'b1, $urandom(), 4'hF);
            tick();
        end
        idle_ticks(4);
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        idle_ticks(4);

        // Unmapped read
        set_req(0, 32'hA000_0000, 1'b0, 32'h0, 4'h0);
        wait_gnt(0);
        idle_ticks(c_RL + 3);

        // m1 request arrives the cycle after an m0 read is granted
        set_req(0, 32'h2000_0000, 1'b0, 32'h0, 4'h0);
        g = cyc;
        tick();
        set_req(1, 32'h8000_0000, 1'b1, 32'h55, 4'hF);
        wait_gnt(1);
        idle_ticks(2);
        chk("m1_gnt_at_G+RL+2", 32'(obs_g[1] - g), 32'(c_RL + 2));
        chk("m0_rvalid_at_G+RL+2", 32'(obs_rv[0] - g), 32'(c_RL + 2));

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (!p_req[m]) begin
                    if ($urandom_range(0, 9) < 4) begin
                        a = $urandom();
                        a[31:28] = 4'($urandom_range(0, 15));
                        set_req(m, a, 1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    p_req[m] = 1'b0;
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
